// File: rtl/alu_multiword_sequencer.sv
// Slices a wide ADD/XOR/AND/pass-A across an external 16-bit ALU, LSW first.
// Optional ALU_OP_COUNT_EN adds a 16-bit output-handshake counter Op_Count.
module alu_multiword_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   input  logic [16*WORDS-1:0]   OpA,
   input  logic [16*WORDS-1:0]   OpB,
   input  logic [1:0]            OpSel,
   input  logic                  Cin,
   output logic [15:0]           AluA,
   output logic [15:0]           AluB,
   output logic [1:0]            AluS,
   output logic                  AluCi,
   input  logic [15:0]           AluR,
   input  logic                  AluCo,
   input  logic                  AluV,
   input  logic                  AluZ,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic [16*WORDS-1:0]   Result,
   output logic                  Co,
   output logic                  V,
   output logic                  Z,
   output logic                  Busy
`ifdef ALU_OP_COUNT_EN
   ,
   output logic [15:0]           Op_Count
`else
`endif
);

   localparam int OW = 16 * WORDS;
   localparam int IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [OW-17:0]   a_q;
   logic [OW-17:0]   b_q;
   logic [1:0]       op_q;
   logic             z_acc;
   logic             is_add;
   logic             accept;

   assign In_Ready = (state == IDLE) | ((state == DONE) & Out_Ready);
   assign accept   = In_Valid & In_Ready;
   assign is_add   = (op_q == 2'b00);

   // ALU drive is registered: the next slice is staged on the edge that
   // consumes the current one, so AluCi carries the just-registered AluCo.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 2'b00;
         z_acc     <= 1'b0;
         AluA      <= '0;
         AluB      <= '0;
         AluS      <= 2'b00;
         AluCi     <= 1'b0;
         Result    <= '0;
         Co        <= 1'b0;
         V         <= 1'b0;
         Z         <= 1'b0;
         Out_Valid <= 1'b0;
         Busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            RUN: begin
               Result[{idx, 4'h0} +: 16] <= AluR;
               z_acc <= z_acc & AluZ;
               if (idx == LAST) begin
                  Co        <= is_add & AluCo;
                  V         <= is_add & AluV;
                  Z         <= z_acc & AluZ;
                  Out_Valid <= 1'b1;
                  Busy      <= 1'b0;
                  state     <= DONE;
                  AluA      <= '0;
                  AluB      <= '0;
                  AluS      <= 2'b00;
                  AluCi     <= 1'b0;
               end else begin
                  idx   <= idx + 1'b1;
                  AluA  <= a_q[15:0];
                  AluB  <= b_q[15:0];
                  AluCi <= is_add & AluCo;
                  a_q   <= a_q >> 16;
                  b_q   <= b_q >> 16;
               end
            end
            DONE: begin
               if (Out_Ready) begin
                  Out_Valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            state <= RUN;
            idx   <= '0;
            op_q  <= OpSel;
            a_q   <= OpA[OW-1:16];
            b_q   <= OpB[OW-1:16];
            z_acc <= 1'b1;
            Busy  <= 1'b1;
            AluA  <= OpA[15:0];
            AluB  <= OpB[15:0];
            AluS  <= OpSel;
            AluCi <= (OpSel == 2'b00) & Cin;
         end
      end
   end

`ifdef ALU_OP_COUNT_EN
   always_ff @(posedge Clk) begin
      if (!Rst_n)
         Op_Count <= '0;
      else if (Out_Valid & Out_Ready)
         Op_Count <= Op_Count + 16'd1;
   end
`else
`endif

endmodule

// File: tb/tb_alu_multiword_sequencer.sv
// Bench for alu_multiword_sequencer: behavioural ALU plus wide-arithmetic
// reference model, directed vectors and randomized operations.
module tb_alu_multiword_sequencer;

   localparam int WORDS = 4;
   localparam int OW = 64;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          In_Valid;
   logic          In_Ready;
   logic [OW-1:0] OpA, OpB;
   logic [1:0]    OpSel;
   logic          Cin;
   logic [15:0]   AluA, AluB;
   logic [1:0]    AluS;
   logic          AluCi;
   logic [15:0]   AluR;
   logic          AluCo, AluV, AluZ;
   logic          Out_Valid;
   logic          Out_Ready;
   logic [OW-1:0] Result;
   logic          Co, V, Z, Busy;

   int checks = 0;
   int errors = 0;

   alu_multiword_sequencer #(.WORDS(WORDS)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .In_Valid(In_Valid), .In_Ready(In_Ready),
      .OpA(OpA), .OpB(OpB), .OpSel(OpSel), .Cin(Cin),
      .AluA(AluA), .AluB(AluB), .AluS(AluS), .AluCi(AluCi),
      .AluR(AluR), .AluCo(AluCo), .AluV(AluV), .AluZ(AluZ),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Result(Result), .Co(Co), .V(V), .Z(Z), .Busy(Busy)
   );

   always #5 Clk = ~Clk;

   // the downstream 16-bit ALU
   always_comb begin
      logic [16:0] s;
      s = '0;
      AluCo = 1'b0;
      AluV = 1'b0;
      unique case (AluS)
         2'b00: begin
            s = {1'b0, AluA} + {1'b0, AluB} + {16'd0, AluCi};
            AluCo = s[16];
            AluV = (AluA[15] == AluB[15]) && (s[15] != AluA[15]);
         end
         2'b01: s = {1'b0, AluA ^ AluB};
         2'b10: s = {1'b0, AluA & AluB};
         default: s = {1'b0, AluA};
      endcase
      AluR = s[15:0];
      AluZ = (s[15:0] == 16'd0);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model
   logic [OW-1:0] e_res;
   logic          e_co, e_v, e_z;
   logic [3:0]    e_ci;

   task automatic model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic [1:0] sel, input logic cin);
      logic [OW:0] sum;
      logic [OW:0] m;
      e_co = 1'b0;
      e_v = 1'b0;
      e_ci = '0;
      unique case (sel)
         2'b00: begin
            sum = {1'b0, a} + {1'b0, b} + (OW + 1)'(cin);
            e_res = sum[OW-1:0];
            e_co = sum[OW];
            e_v = (a[OW-1] == b[OW-1]) && (e_res[OW-1] != a[OW-1]);
            for (int i = 0; i < WORDS; i++) begin
               m = ((OW + 1)'(1) << (16 * i)) - 1;
               sum = ({1'b0, a} & m) + ({1'b0, b} & m) + (OW + 1)'(cin);
               e_ci[i] = sum[16 * i];
            end
         end
         2'b01: e_res = a ^ b;
         2'b10: e_res = a & b;
         default: e_res = a;
      endcase
      e_z = (e_res == '0);
   endtask

   task automatic start(input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic [1:0] sel, input logic cin);
      @(negedge Clk);
      chk("in_ready_before", In_Ready, 1'b1);
      In_Valid = 1'b1;
      OpA = a;
      OpB = b;
      OpSel = sel;
      Cin = cin;
      model(a, b, sel, cin);
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      OpA = {$urandom, $urandom};
      OpB = {$urandom, $urandom};
      OpSel = 2'($urandom);
      Cin = 1'($urandom);
   endtask

   task automatic collect(input string tag);
      int n;
      logic [3:0] ci;
      ci = '0;
      for (n = 0; n < 20; n++) begin
         @(negedge Clk);
         if (Out_Valid) break;
         if (n < 4) ci[n] = AluCi;
      end
      chk({tag, "_latency"}, 64'(n), 64'(WORDS));
      chk({tag, "_ci"}, ci, e_ci);
      chk({tag, "_res"}, Result, e_res);
      chk({tag, "_flags"}, {Co, V, Z}, {e_co, e_v, e_z});
   endtask

   task automatic drain;
      @(posedge Clk);
      #1;
      chk("out_valid_drop", Out_Valid, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [OW-1:0] hr;
      logic [2:0]    hf;
      logic          stable;
      Rst_n = 1'b0;
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      OpA = '0;
      OpB = '0;
      OpSel = '0;
      Cin = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      chk("rst_outs", {Result, Co, V, Z, Out_Valid, Busy},
          {64'd0, 5'd0});
      chk("rst_alu", {AluA, AluB, AluS, AluCi}, 35'd0);
      chk("rst_in_ready", In_Ready, 1'b1);

      start(64'h0000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF00, 2'b00, 1'b1);
      collect("add_wrap");
      chk("add_wrap_ci_all", e_ci, 4'hF);
      drain();

      start(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0);
      collect("add_ovf");
      drain();

      start(64'hC6B8_C6B8_C6B8_C6B8, 64'h15A4_15A4_15A4_15A4, 2'b01, 1'b1);
      collect("xor");
      drain();
      start(64'hC6B8_C6B8_C6B8_C6B8, 64'h15A4_15A4_15A4_15A4, 2'b10, 1'b1);
      collect("and");
      drain();
      start(64'hC6B8_C6B8_C6B8_C6B8, 64'h15A4_15A4_15A4_15A4, 2'b11, 1'b1);
      collect("passa");
      drain();

      // backpressure then simultaneous output/input handshake
      Out_Ready = 1'b0;
      start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'b00, 1'b1);
      collect("bp");
      hr = Result;
      hf = {Co, V, Z};
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         if (!Out_Valid || Result !== hr || {Co, V, Z} !== hf || In_Ready)
            stable = 1'b0;
      end
      chk("bp_stable", stable, 1'b1);
      chk("bp_in_ready", In_Ready, 1'b0);
      Out_Ready = 1'b1;
      In_Valid = 1'b1;
      OpA = 64'hFFFF_0000_FFFF_0000;
      OpB = 64'h0001_FFFF_0001_FFFF;
      OpSel = 2'b00;
      Cin = 1'b1;
      model(OpA, OpB, OpSel, Cin);
      @(posedge Clk);
      #1;
      In_Valid = 1'b0;
      chk("b2b_busy", {Busy, Out_Valid}, 2'b10);
      collect("b2b");
      drain();

      // reset in the middle of an ADD
      start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0);
      repeat (2) @(negedge Clk);
      Rst_n = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b1;
      chk("mid_rst_outs", {Result, Co, V, Z, Out_Valid, Busy},
          {64'd0, 5'd0});
      chk("mid_rst_ready", In_Ready, 1'b1);
      chk("mid_rst_alu", {AluA, AluB, AluS, AluCi}, 35'd0);
      start(64'd1, 64'd1, 2'b00, 1'b0);
      collect("post_rst");
      chk("post_rst_two", Result, 64'd2);
      drain();

      for (int t = 0; t < 30; t++) begin
         logic [OW-1:0] a, b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (t % 7 == 0) b = ~a;
         if (t % 11 == 0) a = '0;
         start(a, b, 2'($urandom), 1'($urandom));
         collect("rnd");
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
